// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-master memory port arbiter: FSM state
// encoding, master identifiers and the round-robin pick helper.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_GRANT_IF = 2'd1,
      ST_GRANT_LS = 2'd2,
      ST_WAIT_RD  = 2'd3
   } arb_state_t;

   localparam logic M_IF = 1'b0;
   localparam logic M_LS = 1'b1;

   // On a tie the master that did not win last time gets the port.
   function automatic logic pick_master(input logic if_req,
                                        input logic ls_req,
                                        input logic last);
      logic pick;
      if (if_req && ls_req)
         pick = (last == M_LS) ? M_IF : M_LS;
      else if (if_req)
         pick = M_IF;
      else
         pick = M_LS;
      return pick;
   endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM slave port between the fetch
// controller (burst reads) and the LSU (single-beat reads/writes).
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int p_addr_bits  = 18,
   parameter int p_data_bits  = 32,
   parameter int p_burst_bits = 4
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_if_read,
   input  logic [p_addr_bits-1:0]  i_if_addr,
   input  logic [p_burst_bits-1:0] i_if_burstcount,
   output logic                    o_if_waitrequest,
   output logic [p_data_bits-1:0]  o_if_readdata,
   output logic                    o_if_readdatavalid,
   input  logic                    i_ls_read,
   input  logic                    i_ls_write,
   input  logic [p_addr_bits-1:0]  i_ls_addr,
   input  logic [p_data_bits-1:0]  i_ls_writedata,
   output logic                    o_ls_waitrequest,
   output logic [p_data_bits-1:0]  o_ls_readdata,
   output logic                    o_ls_readdatavalid,
   output logic                    o_read,
   output logic                    o_write,
   output logic [p_addr_bits-1:0]  o_addr,
   output logic [p_burst_bits-1:0] o_burstcount,
   output logic [p_data_bits-1:0]  o_writedata,
   input  logic                    i_waitrequest,
   input  logic [p_data_bits-1:0]  i_readdata,
   input  logic                    i_readdatavalid,
   output logic [1:0]              o_dbg_state
);

   // Handshake: a command transfers on a rising edge where read or write is
   // high and waitrequest is low; the master must hold it stable until then.
   // Read beats transfer on every edge where readdatavalid is high.

   localparam logic [p_burst_bits-1:0] BURST_ONE = p_burst_bits'(1);

   arb_state_t              state, state_nxt, cur_state;
   logic [p_burst_bits-1:0] beats_left, beats_nxt;
   logic [p_burst_bits-1:0] if_burst;
   logic                    owner, owner_nxt;
   logic                    last_grant, last_nxt;
   logic                    if_req, ls_req;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= ST_IDLE;
         beats_left <= '0;
         owner      <= M_LS;
         last_grant <= M_LS;
      end else begin
         state      <= state_nxt;
         beats_left <= beats_nxt;
         owner      <= owner_nxt;
         last_grant <= last_nxt;
      end
   end

   assign if_req   = i_if_read;
   assign ls_req   = i_ls_read | i_ls_write;
   assign if_burst = (i_if_burstcount == '0) ? BURST_ONE : i_if_burstcount;

   // While reset is held the outputs behave as in IDLE, whatever the register holds.
   assign cur_state = rst ? state : ST_IDLE;

   always_comb begin
      state_nxt        = cur_state;
      beats_nxt        = beats_left;
      owner_nxt        = owner;
      last_nxt         = last_grant;
      o_read           = 1'b0;
      o_write          = 1'b0;
      o_addr           = '0;
      o_burstcount     = '0;
      o_writedata      = '0;
      o_if_waitrequest = 1'b1;
      o_ls_waitrequest = 1'b1;

      case (cur_state)
         ST_IDLE: begin
            if (if_req || ls_req)
               state_nxt = (pick_master(if_req, ls_req, last_grant) == M_IF) ?
                           ST_GRANT_IF : ST_GRANT_LS;
         end

         ST_GRANT_IF: begin
            o_read           = i_if_read;
            o_addr           = i_if_addr;
            o_burstcount     = if_burst;
            o_if_waitrequest = i_waitrequest;
            if (!if_req) begin
               state_nxt = ST_IDLE;
            end else if (!i_waitrequest) begin
               last_nxt  = M_IF;
               owner_nxt = M_IF;
               beats_nxt = if_burst;
               state_nxt = ST_WAIT_RD;
            end
         end

         ST_GRANT_LS: begin
            o_read           = i_ls_read;
            o_write          = i_ls_write;
            o_addr           = i_ls_addr;
            o_writedata      = i_ls_writedata;
            o_burstcount     = BURST_ONE;
            o_ls_waitrequest = i_waitrequest;
            if (!ls_req) begin
               state_nxt = ST_IDLE;
            end else if (!i_waitrequest) begin
               last_nxt = M_LS;
               if (i_ls_write) begin
                  state_nxt = ST_IDLE;
               end else begin
                  owner_nxt = M_LS;
                  beats_nxt = BURST_ONE;
                  state_nxt = ST_WAIT_RD;
               end
            end
         end

         ST_WAIT_RD: begin
            // A count of 0 here cannot occur; treat it as the last beat to avoid a hang.
            if (i_readdatavalid) begin
               beats_nxt = beats_left - BURST_ONE;
               if (beats_left <= BURST_ONE) begin
                  beats_nxt = '0;
                  state_nxt = ST_IDLE;
               end
            end
         end

         default: state_nxt = ST_IDLE;
      endcase
   end

   assign o_if_readdata      = i_readdata;
   assign o_ls_readdata      = i_readdata;
   assign o_if_readdatavalid = (cur_state == ST_WAIT_RD) && (owner == M_IF) && i_readdatavalid;
   assign o_ls_readdatavalid = (cur_state == ST_WAIT_RD) && (owner == M_LS) && i_readdatavalid;
   assign o_dbg_state        = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: bus-functional masters and slave, a
// transaction-order model of the round-robin rule, and per-master data queues.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   localparam int AW = 18;
   localparam int DW = 32;
   localparam int BW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          i_if_read = 1'b0;
   logic [AW-1:0] i_if_addr = '0;
   logic [BW-1:0] i_if_burstcount = '0;
   logic          o_if_waitrequest;
   logic [DW-1:0] o_if_readdata;
   logic          o_if_readdatavalid;
   logic          i_ls_read = 1'b0;
   logic          i_ls_write = 1'b0;
   logic [AW-1:0] i_ls_addr = '0;
   logic [DW-1:0] i_ls_writedata = '0;
   logic          o_ls_waitrequest;
   logic [DW-1:0] o_ls_readdata;
   logic          o_ls_readdatavalid;
   logic          o_read, o_write;
   logic [AW-1:0] o_addr;
   logic [BW-1:0] o_burstcount;
   logic [DW-1:0] o_writedata;
   logic          i_waitrequest;
   logic [DW-1:0] i_readdata;
   logic          i_readdatavalid;
   logic [1:0]    o_dbg_state;

   mem_port_arbiter #(.p_addr_bits(AW), .p_data_bits(DW), .p_burst_bits(BW)) dut (
      .clk(clk), .rst(rst),
      .i_if_read(i_if_read), .i_if_addr(i_if_addr), .i_if_burstcount(i_if_burstcount),
      .o_if_waitrequest(o_if_waitrequest), .o_if_readdata(o_if_readdata),
      .o_if_readdatavalid(o_if_readdatavalid),
      .i_ls_read(i_ls_read), .i_ls_write(i_ls_write), .i_ls_addr(i_ls_addr),
      .i_ls_writedata(i_ls_writedata), .o_ls_waitrequest(o_ls_waitrequest),
      .o_ls_readdata(o_ls_readdata), .o_ls_readdatavalid(o_ls_readdatavalid),
      .o_read(o_read), .o_write(o_write), .o_addr(o_addr), .o_burstcount(o_burstcount),
      .o_writedata(o_writedata), .i_waitrequest(i_waitrequest), .i_readdata(i_readdata),
      .i_readdatavalid(i_readdatavalid), .o_dbg_state(o_dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model / scoreboard ----------------
   bit            exp_order_q[$];   // masters in the order their commands must reach the slave
   logic [DW-1:0] exp_if_q[$];
   logic [DW-1:0] exp_ls_q[$];
   bit            model_last = 1'b1; // last master served; LS after reset

   logic [AW-1:0] cur_if_addr;
   logic [BW-1:0] cur_if_bc;
   logic [AW-1:0] cur_ls_addr;
   bit            cur_ls_write;
   logic [DW-1:0] cur_ls_data;

   int            if_rx_cnt = 0;
   int            ls_rx_cnt = 0;

   // slave knobs and job state
   bit            rand_wait = 1'b0;
   bit            force_wait = 1'b0;
   bit            stray_req = 1'b0;
   int            job_beats = 0;
   bit            job_master;
   bit            job_flush = 1'b0;
   logic [DW-1:0] data_seq = '0;

   task automatic accept_cmd();
      bit m;
      int eff;
      if (exp_order_q.size() == 0) begin
         check("cmd_unexpected", {o_write, o_read}, 0);
         return;
      end
      m = exp_order_q.pop_front();
      if (m == 1'b0) begin
         eff = (cur_if_bc == 0) ? 1 : int'(cur_if_bc);
         check("if_cmd_kind", {o_write, o_read}, 2'b01);
         check("if_cmd_addr", o_addr, cur_if_addr);
         check("if_cmd_burst", o_burstcount, eff);
         job_beats  = eff;
         job_master = 1'b0;
         job_flush  = 1'b0;
      end else begin
         check("ls_cmd_kind", {o_write, o_read}, cur_ls_write ? 2'b10 : 2'b01);
         check("ls_cmd_addr", o_addr, cur_ls_addr);
         check("ls_cmd_burst", o_burstcount, 1);
         if (cur_ls_write) begin
            check("ls_cmd_wdata", o_writedata, cur_ls_data);
         end else begin
            job_beats  = 1;
            job_master = 1'b1;
            job_flush  = 1'b0;
         end
      end
   endtask

   // ---------------- slave model ----------------
   initial begin : slave
      bit acc;
      i_waitrequest   = 1'b0;
      i_readdatavalid = 1'b0;
      i_readdata      = '0;
      forever begin
         @(negedge clk);
         acc = rst && (o_read || o_write) && !i_waitrequest;
         if (acc) accept_cmd();
         @(posedge clk);
         #1;
         i_waitrequest = force_wait || (rand_wait && ($urandom_range(0, 3) == 0));
         if (stray_req && job_beats == 0) begin
            i_readdatavalid = 1'b1;
            i_readdata      = 32'h0000_DEAD;
            stray_req       = 1'b0;
         end else if (job_beats > 0 && $urandom_range(0, 2) != 0) begin
            data_seq        = data_seq + 1;
            i_readdatavalid = 1'b1;
            i_readdata      = data_seq;
            job_beats--;
            if (!job_flush) begin
               if (job_master) exp_ls_q.push_back(data_seq);
               else            exp_if_q.push_back(data_seq);
            end
         end else begin
            i_readdatavalid = 1'b0;
            i_readdata      = $urandom;
         end
      end
   end

   // ---------------- read-data receivers ----------------
   initial begin : receiver
      forever begin
         @(negedge clk);
         if (o_if_readdatavalid) begin
            if (exp_if_q.size() == 0) check("if_unexpected_beat", o_if_readdatavalid, 0);
            else                      check("if_rdata", o_if_readdata, exp_if_q.pop_front());
            if_rx_cnt++;
         end
         if (o_ls_readdatavalid) begin
            if (exp_ls_q.size() == 0) check("ls_unexpected_beat", o_ls_readdatavalid, 0);
            else                      check("ls_rdata", o_ls_readdata, exp_ls_q.pop_front());
            ls_rx_cnt++;
         end
      end
   end

   // ---------------- master driver tasks ----------------
   task automatic if_cmd(input logic [AW-1:0] a, input logic [BW-1:0] bc);
      int n = 0;
      @(posedge clk);
      #1;
      cur_if_addr = a;
      cur_if_bc   = bc;
      i_if_read   = 1'b1;
      i_if_addr   = a;
      i_if_burstcount = bc;
      do begin
         @(negedge clk);
         n++;
      end while (o_if_waitrequest && n < 400);
      check("if_cmd_accepted", o_if_waitrequest, 0);
      @(posedge clk);
      #1;
      i_if_read       = 1'b0;
      i_if_addr       = $urandom;
      i_if_burstcount = $urandom;
   endtask

   task automatic ls_cmd(input logic [AW-1:0] a, input bit wr, input logic [DW-1:0] wd);
      int n = 0;
      @(posedge clk);
      #1;
      cur_ls_addr    = a;
      cur_ls_write   = wr;
      cur_ls_data    = wd;
      i_ls_read      = !wr;
      i_ls_write     = wr;
      i_ls_addr      = a;
      i_ls_writedata = wd;
      do begin
         @(negedge clk);
         n++;
      end while (o_ls_waitrequest && n < 400);
      check("ls_cmd_accepted", o_ls_waitrequest, 0);
      @(posedge clk);
      #1;
      i_ls_read      = 1'b0;
      i_ls_write     = 1'b0;
      i_ls_addr      = $urandom;
      i_ls_writedata = $urandom;
   endtask

   task automatic wait_rx(input int target);
      int n = 0;
      while (if_rx_cnt < target && n < 300) begin
         @(negedge clk);
         #2;
         n++;
      end
      check("if_rx_progress", if_rx_cnt >= target, 1);
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_order_q.size() != 0 || job_beats != 0 ||
              exp_if_q.size() != 0 || exp_ls_q.size() != 0) && n < 600) begin
         @(negedge clk);
         #2;
         n++;
      end
      check("drain_done", n < 600, 1);
      repeat (2) @(negedge clk);
      check("idle_state", o_dbg_state, ST_IDLE);
      check("idle_if_wait", o_if_waitrequest, 1);
      check("idle_ls_wait", o_ls_waitrequest, 1);
   endtask

   task automatic run_round(input bit do_if, input bit do_ls, input logic [AW-1:0] a,
                            input logic [BW-1:0] bc, input bit wr, input logic [DW-1:0] wd);
      bit first;
      if (do_if && do_ls) begin
         first = (model_last == 1'b1) ? 1'b0 : 1'b1;
         exp_order_q.push_back(first);
         exp_order_q.push_back(!first);
         model_last = !first;
      end else if (do_if) begin
         exp_order_q.push_back(1'b0);
         model_last = 1'b0;
      end else if (do_ls) begin
         exp_order_q.push_back(1'b1);
         model_last = 1'b1;
      end
      fork
         if (do_if) if_cmd(a, bc);
         if (do_ls) ls_cmd(a ^ 18'h1, wr, wd);
      join
      drain();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_read"}, o_read, 0);
      check({tag, "_write"}, o_write, 0);
      check({tag, "_addr"}, o_addr, 0);
      check({tag, "_burst"}, o_burstcount, 0);
      check({tag, "_wdata"}, o_writedata, 0);
      check({tag, "_if_rdv"}, o_if_readdatavalid, 0);
      check({tag, "_ls_rdv"}, o_ls_readdatavalid, 0);
      check({tag, "_if_wait"}, o_if_waitrequest, 1);
      check({tag, "_ls_wait"}, o_ls_waitrequest, 1);
   endtask

   // ---------------- main sequence ----------------
   initial begin : main
      int base;
      int n;
      bit do_if, do_ls;

      // reset
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      check("reset_state", o_dbg_state, ST_IDLE);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);

      // ties straight after reset: fetch first, then alternation
      run_round(1'b1, 1'b1, 18'h01000, 4'd3, 1'b0, 32'h0);
      run_round(1'b1, 1'b1, 18'h02000, 4'd2, 1'b1, 32'h1234_5678);
      run_round(1'b1, 1'b1, 18'h03000, 4'd1, 1'b0, 32'h0);

      // fetch burst alone, data 1..8, with grant latency check
      base = if_rx_cnt;
      n = ls_rx_cnt;
      data_seq = '0;
      exp_order_q.push_back(1'b0);
      model_last = 1'b0;
      fork
         if_cmd(18'h00100, 4'd8);
         begin
            @(negedge clk);
            #2;
            check("grant_lat_idle", o_read, 0);
            @(negedge clk);
            #2;
            check("grant_lat_cmd", o_read, 1);
            check("grant_lat_burst", o_burstcount, 8);
         end
      join
      drain();
      check("burst_if_beats", if_rx_cnt - base, 8);
      check("burst_ls_beats", ls_rx_cnt - n, 0);

      // LSU write stalled by the slave for three cycles
      force_wait = 1'b1;
      exp_order_q.push_back(1'b1);
      model_last = 1'b1;
      fork
         ls_cmd(18'h00333, 1'b1, 32'hCAFE_0001);
         begin
            n = 0;
            do begin
               @(negedge clk);
               #2;
               n++;
            end while (!o_write && n < 20);
            for (int k = 0; k < 3; k++) begin
               check("wr_held", o_write, 1);
               check("wr_addr_stable", o_addr, 18'h00333);
               check("wr_data_stable", o_writedata, 32'hCAFE_0001);
               check("wr_ls_stalled", o_ls_waitrequest, 1);
               check("wr_if_blocked", o_if_waitrequest, 1);
               if (k == 2) force_wait = 1'b0;
               @(negedge clk);
               #2;
            end
            check("wr_accept_cycle4", o_ls_waitrequest, 0);
            check("wr_if_blocked_c4", o_if_waitrequest, 1);
            @(negedge clk);
            #2;
            check("wr_after_accept", o_write, 0);
         end
      join
      drain();

      // LSU request arriving mid-way through an 8-beat fetch burst
      base = if_rx_cnt;
      exp_order_q.push_back(1'b0);
      exp_order_q.push_back(1'b1);
      model_last = 1'b1;
      fork
         if_cmd(18'h00100, 4'd8);
         begin
            wait_rx(base + 3);
            ls_cmd(18'h00200, 1'b0, 32'h0);
         end
         begin
            wait_rx(base + 4);
            n = 0;
            while (if_rx_cnt < base + 8 && n < 200) begin
               check("ls_held_off", o_ls_waitrequest, 1);
               @(negedge clk);
               #2;
               n++;
            end
            @(negedge clk);
            #2;
            check("idle_after_burst", o_dbg_state, ST_IDLE);
            check("no_cmd_in_idle", o_read, 0);
            @(negedge clk);
            #2;
            check("ls_granted", o_read, 1);
            check("ls_grant_addr", o_addr, 18'h00200);
         end
      join
      drain();

      // reset in the middle of a burst; late beats must be dropped
      base = if_rx_cnt;
      exp_order_q.push_back(1'b0);
      model_last = 1'b0;
      if_cmd(18'h00100, 4'd8);
      wait_rx(base + 2);
      job_flush = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("midrst");
      @(posedge clk);
      #1;
      @(negedge clk);
      check("midrst_state", o_dbg_state, ST_IDLE);
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_last = 1'b1;
      n = 0;
      while (job_beats != 0 && n < 100) begin
         @(negedge clk);
         #2;
         n++;
      end
      repeat (2) @(negedge clk);
      check("midrst_no_late_beats", if_rx_cnt - base, 2);
      check("midrst_idle", o_dbg_state, ST_IDLE);
      job_flush = 1'b0;
      run_round(1'b1, 1'b0, 18'h00480, 4'd5, 1'b0, 32'h0);
      run_round(1'b1, 1'b1, 18'h00500, 4'd2, 1'b0, 32'h0);

      // stray beat in IDLE
      stray_req = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         #2;
         n++;
      end while (!i_readdatavalid && n < 20);
      check("stray_if_rdv", o_if_readdatavalid, 0);
      check("stray_ls_rdv", o_ls_readdatavalid, 0);
      check("stray_if_data_pass", o_if_readdata, 32'h0000_DEAD);
      check("stray_ls_data_pass", o_ls_readdata, 32'h0000_DEAD);
      repeat (2) @(negedge clk);

      // burstcount 0 from fetch behaves as a single beat
      run_round(1'b1, 1'b0, 18'h00600, 4'd0, 1'b0, 32'h0);

      // randomized traffic with slave stalls
      rand_wait = 1'b1;
      for (int r = 0; r < 40; r++) begin
         do_if = 1'($urandom_range(0, 1));
         do_ls = do_if ? 1'($urandom_range(0, 1)) : 1'b1;
         data_seq = $urandom;
         run_round(do_if, do_ls, AW'($urandom), BW'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)), $urandom);
      end
      rand_wait = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-master Avalon-MM arbiter that shares the single external memory port between the instruction fetch controller (burst reads) and the data load/store unit (single-beat reads and writes). It sits between `mInst_fetch_ctrl` / the LSU and the memory slave. It owns the slave port for one whole transaction, including all read-data beats, and routes returned data only to the master that issued the command. Arbitration is round-robin.

## Interface
- `p_addr_bits`, 18, address width
- `p_data_bits`, 32, data width
- `p_burst_bits`, 4, burstcount width (max burst 2^p_burst_bits − 1)

Ports:
- `clk`  in  1  sole clock, all logic on rising edge
- `rst`  in  1  synchronous, active-low reset (0 = reset)
- `i_if_read`  in  1  fetch read request
- `i_if_addr`  in  p_addr_bits  fetch address
- `i_if_burstcount`  in  p_burst_bits  fetch burst length, ≥1
- `o_if_waitrequest`  out  1  fetch command stall
- `o_if_readdata`  out  p_data_bits  fetch read data
- `o_if_readdatavalid`  out  1  fetch beat valid
- `i_ls_read`  in  1  LSU read request
- `i_ls_write`  in  1  LSU write request, never together with `i_ls_read`
- `i_ls_addr`  in  p_addr_bits  LSU address
- `i_ls_writedata`  in  p_data_bits  LSU write data
- `o_ls_waitrequest`  out  1  LSU command stall
- `o_ls_readdata`  out  p_data_bits  LSU read data
- `o_ls_readdatavalid`  out  1  LSU beat valid
- `o_read`, `o_write`  out  1  slave command
- `o_addr`  out  p_addr_bits  slave address
- `o_burstcount`  out  p_burst_bits  slave burst length
- `o_writedata`  out  p_data_bits  slave write data
- `i_waitrequest`  in  1  slave stall
- `i_readdata`  in  p_data_bits  slave read data
- `i_readdatavalid`  in  1  slave beat valid

## Operation
- **States:** IDLE, GRANT_IF, GRANT_LS, WAIT_RD.
- **IDLE:** no slave command is driven.
  - One requester active: the state moves to that requester's GRANT state next cycle.
  - Both active: grant the master that was not granted last. The `last_grant` flop resets to LS, so fetch wins the first tie.
- **GRANT_x:** the slave command is a combinational pass-through of master x.
  - The other master sees `waitrequest` = 1.
  - Master x sees `waitrequest` = `i_waitrequest`.
  - The command is accepted when `o_read` or `o_write` is high and `i_waitrequest` = 0. On acceptance, `last_grant` ← x.
  - Accepted write: return to IDLE. LSU writes are always burstcount 1.
  - Accepted read: load `beats_left` ← burstcount (1 for LSU), latch `owner` ← x, go to WAIT_RD.
  - If x drops its request before acceptance, return to IDLE. This is legal only while waitrequest is low; otherwise it is a master protocol violation and is unsupported.
- **WAIT_RD:**
  - Both masters see `waitrequest` = 1. No slave command is driven.
  - Each `i_readdatavalid` beat is forwarded to `owner` only and decrements `beats_left`.
  - On the beat where `beats_left` = 1, return to IDLE.
- **Readdata routing:**
  - `o_if_readdata` and `o_ls_readdata` are driven combinationally from `i_readdata`.
  - Each `readdatavalid` is gated by `owner` and the WAIT_RD state.
  - A `i_readdatavalid` outside WAIT_RD is dropped. Stray beats after a reset are dropped.
- **Burstcount 0 from fetch:** treated as 1.
- **Reset (`rst` = 0, any state, including mid-burst):**
  - State IDLE; `beats_left` 0; `owner` and `last_grant` LS.
  - Beats still arriving are discarded. The fetch controller must flush on reset.

## Timing
- **Reset values:**
  - `o_read` = `o_write` = 0, `o_addr` = 0, `o_burstcount` = 0, `o_writedata` = 0.
  - Both `readdatavalid` = 0.
  - Both `waitrequest` = 1 while in IDLE, reset included.
- **Grant latency:** a request seen in IDLE at edge N is granted in cycle N+1. The earliest slave command is 1 cycle after the request is raised.
- **Command to next grant:**
  - Write: back to IDLE on the cycle after acceptance. The next grant is 2 cycles after acceptance.
  - Read: IDLE on the cycle after the last beat.
- **Readdata path:** zero-cycle combinational pass-through. There is no added latency.
- **Simultaneous events:**
  - A new request arriving in the same cycle as the last read beat is evaluated in IDLE next cycle.
  - Requests during GRANT or WAIT_RD are held off by waitrequest.

## Structure
- Shared package `mem_arb_pkg`:
  - state encoding constants `ST_IDLE`/`ST_GRANT_IF`/`ST_GRANT_LS`/`ST_WAIT_RD`
  - master ID constants `M_IF`/`M_LS`
- Single flat module, no sub-modules. The beat counter is inline.

## Test plan
- **Fetch burst alone:** if read, addr 0x00100, burstcount 8; slave returns 8 beats 1..8 with gaps → exactly 8 `o_if_readdatavalid` pulses with data 1..8; `o_ls_readdatavalid` never high; IDLE after beat 8.
- **Tie after reset:** if and ls read asserted together → fetch granted first; after its completion the LSU is granted; a second tie grants fetch again (alternation).
- **LSU write with `i_waitrequest` high for 3 cycles:** `o_write` is held with addr/data stable for 3 cycles; accepted on cycle 4; fetch sees waitrequest = 1 throughout.
- **Mid-burst contention:** LSU requests during beat 3 of an 8-beat fetch burst → `o_ls_waitrequest` = 1 until fetch completes; LSU granted the cycle after IDLE is reached.
- **Reset mid-burst:** `rst` = 0 after beat 2 of 8; beats 3..8 arrive after reset → no `readdatavalid` on either side; all outputs at reset values; a subsequent fetch works normally.
- **Stray beat:** `i_readdatavalid` pulsed in IDLE with data 0xDEAD → dropped on both masters.
